// File: rtl/conv_result_collector.sv
// conv_result_collector
// Packs a stream of id-tagged scalar float results from the convolution
// forward layer into WIDTH-lane vectors, buffers completed vectors in a
// DEPTH-entry first-word-fall-through FIFO and drains them downstream.
//
// Optional feature macro: CONV_COLLECT_RELU_EN
//   defined   -> any accepted result with bit 31 set is written as +0.0
//   undefined -> results are written bit-exact, no rectification logic
//
// Handshake: the input side has no backpressure; a result is taken on
// every cycle in_valid is high. The output side transfers the head entry
// on each rising edge where out_valid && out_ready; out_valid never drops
// without a transfer, and out_data/out_tag hold the last head value while
// out_valid is low.
module conv_result_collector #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  input  logic [7:0]            in_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH*32-1:0]   out_data,
  output logic [7:0]            out_tag,
  output logic                  overflow,
  output logic                  dup_err,
  output logic                  seq_err,
  input  logic                  err_clr
);

  localparam int L  = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Assembly state
  logic [31:0]          lane_q [WIDTH];
  logic [31:0]          lane_d [WIDTH];
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [7:0]           grp_q, grp_d;

  // FIFO state
  logic [WIDTH*32-1:0]  mem_q [DEPTH];
  logic [WIDTH*32-1:0]  mem_d [DEPTH];
  logic [7:0]           tag_q [DEPTH];
  logic [7:0]           tag_d [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH*32-1:0]  head_data_q, head_data_d;
  logic [7:0]           head_tag_q, head_tag_d;

  // Sticky flags
  logic                 ovf_q, ovf_d;
  logic                 dup_q, dup_d;
  logic                 seq_q, seq_d;

  // Front-end decode
  logic [31:0]          wdata;
  logic [L-1:0]         slot;
  logic [7:0]           in_grp;
  logic [WIDTH-1:0]     slot_bit;
  logic [WIDTH-1:0]     mask_set;

  // Events and FIFO control
  logic                 dup_ev, seq_ev, ovf_ev;
  logic                 push_req, push_ok, pop, full;
  logic [WIDTH*32-1:0]  push_vec;
  logic [7:0]           push_tag;

  // Decode the incoming result: lane slot, group and (optionally) rectified data
  always_comb begin
    slot     = in_id[L-1:0];
    in_grp   = 8'(in_id >> L);
    slot_bit = WIDTH'(1) << slot;
`ifdef CONV_COLLECT_RELU_EN
    // Sign bit set covers negatives, -0.0 and negative NaNs alike
    wdata    = in_data[31] ? 32'h0000_0000 : in_data;
`else
    wdata    = in_data;
`endif
  end

  // Assembly: accept, duplicate and group-change rules, completion detect
  always_comb begin
    for (int k = 0; k < WIDTH; k++) lane_d[k] = lane_q[k];
    mask_d   = mask_q;
    grp_d    = grp_q;
    mask_set = mask_q;
    dup_ev   = 1'b0;
    seq_ev   = 1'b0;
    push_req = 1'b0;
    push_tag = grp_q;
    if (in_valid) begin
      if ((mask_q != '0) && (in_grp != grp_q)) begin
        // Group moved on before completion: drop the partial vector and
        // let this result open a new one. A single lane can never complete
        // a vector since WIDTH >= 2.
        seq_ev       = 1'b1;
        lane_d[slot] = wdata;
        mask_d       = slot_bit;
        grp_d        = in_grp;
      end else if (mask_q[slot]) begin
        // Same group, slot already filled: first value wins
        dup_ev = 1'b1;
      end else begin
        lane_d[slot] = wdata;
        mask_set     = mask_q | slot_bit;
        if (mask_q == '0) grp_d = in_grp;
        if (&mask_set) begin
          push_req = 1'b1;
          push_tag = grp_d;
          mask_d   = '0;
        end else begin
          mask_d   = mask_set;
        end
      end
    end
    // Completed vector includes the lane written on this edge
    push_vec = '0;
    for (int k = 0; k < WIDTH; k++) push_vec[k*32 +: 32] = lane_d[k];
  end

  // FIFO control: push/pop, pointers, occupancy and the registered head
  always_comb begin
    pop      = (count_q != '0) && out_ready;
    full     = (count_q == CW'(DEPTH));
    // A pop on the same edge frees the slot a full FIFO needs
    push_ok  = push_req && (!full || pop);
    ovf_ev   = push_req && full && !pop;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      tag_d[i] = tag_q[i];
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_vec;
      tag_d[wr_ptr_q] = push_tag;
    end
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    // The head register tracks the entry at rd_ptr after this edge; when
    // the FIFO drains it keeps the last head so outputs never go stale-X.
    head_data_d = head_data_q;
    head_tag_d  = head_tag_q;
    if (count_d != '0) begin
      if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
        head_data_d = push_vec;
        head_tag_d  = push_tag;
      end else begin
        head_data_d = mem_q[rd_ptr_d];
        head_tag_d  = tag_q[rd_ptr_d];
      end
    end
  end

  // Sticky flags: an event on the same edge as err_clr keeps the flag set
  always_comb begin
    ovf_d = ovf_ev | (ovf_q & ~err_clr);
    dup_d = dup_ev | (dup_q & ~err_clr);
    seq_d = seq_ev | (seq_q & ~err_clr);
  end

  // State registers; reset wipes all lane and FIFO data, nothing survives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < WIDTH; k++) lane_q[k] <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        tag_q[i] <= '0;
      end
      mask_q      <= '0;
      grp_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_data_q <= '0;
      head_tag_q  <= '0;
      ovf_q       <= 1'b0;
      dup_q       <= 1'b0;
      seq_q       <= 1'b0;
    end else begin
      for (int k = 0; k < WIDTH; k++) lane_q[k] <= lane_d[k];
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
        tag_q[i] <= tag_d[i];
      end
      mask_q      <= mask_d;
      grp_q       <= grp_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_tag_q  <= head_tag_d;
      ovf_q       <= ovf_d;
      dup_q       <= dup_d;
      seq_q       <= seq_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = head_data_q;
  assign out_tag   = head_tag_q;
  assign overflow  = ovf_q;
  assign dup_err   = dup_q;
  assign seq_err   = seq_q;

endmodule
